branch_resolve_unit: RTL

- Next-generation RISC-V conditional-branch unit for the EX stage.
- Resolves all six B-type conditions with correct signed/unsigned compares and registers the outcome.
- Carries a parametrised 2-bit-counter branch history table (BHT) that fetch reads and EX trains.
- Flags mispredictions and produces the redirect PC and pipeline flush.

---
 rtl/branch_pkg.sv | 30 +++
 rtl/bht_2bit.sv | 34 +++
 rtl/branch_resolve_unit.sv | 117 +++++++++++
 3 files changed

// File: rtl/branch_pkg.sv
// Shared types and constants for the branch resolve unit and its history table.
package branch_pkg;

    typedef enum logic [2:0] {
        BR_EQ  = 3'b000,
        BR_NE  = 3'b001,
        BR_LT  = 3'b100,
        BR_GE  = 3'b101,
        BR_LTU = 3'b110,
        BR_GEU = 3'b111
    } brfunc_t;

    typedef logic [1:0] bht_ctr_t;

    localparam bht_ctr_t    BHT_INIT = 2'b01;
    localparam int unsigned PC_STEP  = 4;

    // Saturating 2-bit counter step: taken counts up, not-taken counts down.
    function automatic bht_ctr_t ctr_next(input bht_ctr_t c, input logic taken);
        bht_ctr_t r;
        r = c;
        if (taken) begin
            if (c != 2'b11) r = c + 2'b01;
        end else begin
            if (c != 2'b00) r = c - 2'b01;
        end
        return r;
    endfunction

endpackage

// File: rtl/bht_2bit.sv
// Branch history table of 2-bit saturating counters: combinational read,
// synchronous update, synchronous reset of every entry to weakly not-taken.
module bht_2bit
    import branch_pkg::*;
#(
    parameter int unsigned BHT_BITS = 6
) (
    input  logic                clock,
    input  logic                nReset,
    input  logic [BHT_BITS-1:0] rd_idx,
    output bht_ctr_t            rd_ctr,
    input  logic                wr_en,
    input  logic [BHT_BITS-1:0] wr_idx,
    input  logic                wr_taken
);

    localparam int unsigned ENTRIES = 32'(1) << BHT_BITS;

    bht_ctr_t tbl [ENTRIES];

    always_ff @(posedge clock) begin
        if (!nReset) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                tbl[i] <= BHT_INIT;
            end
        end else if (wr_en) begin
            tbl[wr_idx] <= ctr_next(tbl[wr_idx], wr_taken);
        end
    end

    // Read sees the pre-update value when the same entry is written this cycle.
    assign rd_ctr = tbl[rd_idx];

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage conditional branch resolution with BHT prediction and mispredict redirect.
// Optional BRANCH_STATS_EN adds saturating branch/mispredict counters.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int unsigned n        = 32,
    parameter int unsigned PC_W     = 32,
    parameter int unsigned BHT_BITS = 6
) (
    input  logic            clock,
    input  logic            nReset,
    input  logic [PC_W-1:0] f_pc,
    output logic            f_pred_taken,
    input  logic            ex_valid,
    input  logic [2:0]      ex_brfunc,
    input  logic [n-1:0]    ex_A,
    input  logic [n-1:0]    ex_B,
    input  logic [PC_W-1:0] ex_pc,
    input  logic [PC_W-1:0] ex_target,
    input  logic            ex_pred_taken,
    output logic            res_valid,
    output logic            brnch,
    output logic            mispredict,
    output logic [PC_W-1:0] redirect_pc,
    output logic            illegal
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
`endif
);

    function automatic logic br_cond(input logic [2:0] f,
                                     input logic [n-1:0] a,
                                     input logic [n-1:0] b);
        logic r;
        r = 1'b0;
        case (f)
            BR_EQ:   r = (a == b);
            BR_NE:   r = (a != b);
            BR_LT:   r = ($signed(a) <  $signed(b));
            BR_GE:   r = ($signed(a) >= $signed(b));
            BR_LTU:  r = (a <  b);
            BR_GEU:  r = (a >= b);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    logic            accept_c;
    logic            illegal_c;
    logic            taken_c;
    logic            mispredict_c;
    logic [PC_W-1:0] redirect_c;
    bht_ctr_t        f_ctr;
    logic            unused_fpc_bits;

    // The registered mispredict doubles as the one-cycle wrong-path squash flag.
    always_comb begin
        accept_c     = ex_valid && !mispredict;
        illegal_c    = (ex_brfunc[2:1] == 2'b01);
        taken_c      = !illegal_c && br_cond(ex_brfunc, ex_A, ex_B);
        mispredict_c = accept_c && (taken_c != ex_pred_taken);
        redirect_c   = taken_c ? ex_target : ex_pc + PC_W'(PC_STEP);
    end

    always_ff @(posedge clock) begin
        if (!nReset) begin
            res_valid   <= 1'b0;
            brnch       <= 1'b0;
            mispredict  <= 1'b0;
            illegal     <= 1'b0;
            redirect_pc <= '0;
        end else begin
            res_valid  <= accept_c;
            brnch      <= accept_c && taken_c;
            mispredict <= mispredict_c;
            illegal    <= accept_c && illegal_c;
            if (accept_c) begin
                redirect_pc <= redirect_c;
            end
        end
    end

    bht_2bit #(
        .BHT_BITS (BHT_BITS)
    ) u_bht (
        .clock    (clock),
        .nReset   (nReset),
        .rd_idx   (f_pc[BHT_BITS+1:2]),
        .rd_ctr   (f_ctr),
        .wr_en    (accept_c && !illegal_c),
        .wr_idx   (ex_pc[BHT_BITS+1:2]),
        .wr_taken (taken_c)
    );

    assign f_pred_taken    = f_ctr[1];
    assign unused_fpc_bits = ^{f_pc[PC_W-1:BHT_BITS+2], f_pc[1:0]};

`ifdef BRANCH_STATS_EN
    // Counters watch the registered outputs and stick at all-ones.
    always_ff @(posedge clock) begin
        if (!nReset) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (res_valid && (stat_branches != 32'hFFFF_FFFF)) begin
                stat_branches <= stat_branches + 32'd1;
            end
            if (mispredict && (stat_mispredicts != 32'hFFFF_FFFF)) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end
`endif

endmodule
